interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  Drives the processor's interrupt/RTI sequencing; it is the source of interrupt, stall, flush and int_mem_selector.
//  Latches external int_req, drains the pipeline, then pushes PC[31:16], PC[15:0] and flags onto the stack.
//  Redirects fetch to the ISR vector. On RTI it pops the three words back and restores PC and flags.
//  Sits beside the fetch PC mux and the memory stage.
// PARAMETERS
//  FLUSH_CYCLES  3             cycles of stall+flush before the first push/pop (pipeline drain)
//  VECTOR_ADDR   32'h0000_0000 ISR entry PC driven on vector_pc
// PORTS
//  clk             in   1   system clock, rising edge
//  reset           in   1   asynchronous, active-high
//  int_req         in   1   external interrupt request, level; rising edge = new request
//  rti_req         in   1   one-cycle pulse from decode: RTI instruction decoded
//  resume_pc       in   32  PC of next unexecuted instruction; sampled on leaving IDLE for interrupt
//  cur_flags       in   4   CCR flags; sampled together with resume_pc
//  mem_rdata       in   16  data-memory read data, valid in the same cycle as mem_read
//  stall           out  1   freeze PC and IF/ID
//  flush           out  1   flush IF/ID, ID/IE, IE/IM
//  interrupt       out  1   1-cycle pulse: PC mux selects vector_pc
//  vector_pc       out  32  constant VECTOR_ADDR
//  int_mem_sel     out  2   memory-stage mux: 00 pipeline, 01 PC hi, 10 PC lo, 11 flags
//  push_data       out  16  word to write during a push cycle
//  mem_write       out  1   push strobe (with dec_sp)
//  mem_read        out  1   pop strobe (with inc_sp)
//  dec_sp / inc_sp out  1   SP adjust, same cycle as mem_write / mem_read
//  pc_restore      out  1   1-cycle pulse: PC mux loads restored_pc
//  restored_pc     out  32  popped PC
//  flags_restore   out  1   1-cycle pulse: CCR loads restored_flags
//  restored_flags  out  4   popped flags (mem_rdata[3:0])
//  in_isr          out  1   1 from vector issue until RTI completes
// BEHAVIOUR
//  Reset: state=IDLE, pending=0, in_isr=0, all outputs 0 except vector_pc=VECTOR_ADDR; holds if asserted mid-sequence.
//  Edge detect: pending set on int_req 0->1 at any time (int_req_q registered).
//   pending is cleared only on IDLE->I_DRAIN; further edges while pending=1 coalesce.
//  FSM, one state per cycle unless noted:
//   IDLE    : rti_req & in_isr -> R_DRAIN. Else pending & !in_isr -> I_DRAIN; latch saved_pc, saved_flags.
//             rti_req with in_isr=0 is ignored. Simultaneous rti_req and pending: RTI wins.
//   I_DRAIN : stall=flush=1 for FLUSH_CYCLES cycles -> PUSH_HI
//   PUSH_HI : mem_write, dec_sp, sel=01, push_data=saved_pc[31:16] -> PUSH_LO
//   PUSH_LO : mem_write, dec_sp, sel=10, push_data=saved_pc[15:0]  -> PUSH_FL
//   PUSH_FL : mem_write, dec_sp, sel=11, push_data={12'b0,saved_flags} -> VECTOR
//   VECTOR  : interrupt=1, stall=0; in_isr<=1 -> IDLE
//   R_DRAIN : stall=flush=1 for FLUSH_CYCLES cycles -> POP_FL
//   POP_FL  : mem_read, inc_sp, sel=11; restored_flags<=mem_rdata[3:0] -> POP_LO
//   POP_LO  : mem_read, inc_sp, sel=10; restored_pc[15:0]<=mem_rdata -> POP_HI
//   POP_HI  : mem_read, inc_sp, sel=01; restored_pc[31:16]<=mem_rdata -> RESTORE
//   RESTORE : pc_restore=1, flags_restore=1; in_isr<=0 -> IDLE
//  stall=1 in every non-IDLE state except VECTOR and RESTORE; flush=1 only in the drain states.
//  Latency: int_req edge in IDLE -> interrupt pulse after FLUSH_CYCLES+4 cycles (edge-detect cycle + drain + 3 pushes).
//   RTI: rti_req -> pc_restore after FLUSH_CYCLES+4 cycles.
//  Pop order is the exact reverse of push order, so the stack is LIFO-consistent. Nesting is not supported.
//   An interrupt arriving during ISR waits in pending and is serviced right after RESTORE.
// TESTING
//  T1 reset high mid-PUSH_LO -> next cycle all strobes 0, state IDLE, pending=0, in_isr=0.
//  T2 resume_pc=32'h0001_0024, flags=4'b1010, int_req edge -> pushes 16'h0001, 16'h0024, 16'h000A with sel 01/10/11.
//     Then interrupt pulse at edge+7 (FLUSH_CYCLES=3); in_isr=1.
//  T3 after T2, rti_req with mem_rdata 000A/0024/0001 on successive pops -> restored_pc=32'h0001_0024, flags=4'b1010.
//     pc_restore pulses at rti+7; in_isr=0.
//  T4 rti_req while in_isr=0 -> no stall, no strobes, state stays IDLE.
//  T5 int_req edge during ISR -> pending held, no push until RESTORE; interrupt sequence starts the next IDLE cycle.
//  T6 rti_req and a pending interrupt in the same IDLE cycle -> RTI sequence first, then interrupt entry.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Sequences interrupt entry and RTI return for the pipelined processor.
//   On a rising edge of int_req it drains the pipeline and pushes PC[31:16],
//   PC[15:0] and the CCR flags onto the stack. It then issues a one-cycle
//   redirect to vector_pc. On RTI it drains again, pops the three words in
//   reverse order and pulses pc_restore / flags_restore.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   int_req           external interrupt request (level, rising edge = new request)
//   rti_req           one-cycle pulse from decode when RTI is decoded
//   resume_pc         PC of the next unexecuted instruction, sampled on interrupt entry
//   cur_flags         CCR flags, sampled together with resume_pc
//   mem_rdata         data-memory read data, valid in the same cycle as mem_read
//   stall, flush      pipeline freeze / flush controls
//   interrupt         one-cycle pulse: fetch PC mux selects vector_pc
//   vector_pc         ISR entry address (VECTOR_ADDR)
//   int_mem_sel       memory-stage mux: 00 pipeline, 01 PC hi, 10 PC lo, 11 flags
//   push_data         word written during a push cycle
//   mem_write, dec_sp push strobe and stack-pointer decrement
//   mem_read, inc_sp  pop strobe and stack-pointer increment
//   pc_restore        one-cycle pulse: fetch PC mux loads restored_pc
//   restored_pc       popped PC
//   flags_restore     one-cycle pulse: CCR loads restored_flags
//   restored_flags    popped flags
//   in_isr            high from vector issue until RTI completes
module interrupt_controller #(
  parameter int unsigned FLUSH_CYCLES = 3,
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic        rti_req,
  input  logic [31:0] resume_pc,
  input  logic [3:0]  cur_flags,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        flush,
  output logic        interrupt,
  output logic [31:0] vector_pc,
  output logic [1:0]  int_mem_sel,
  output logic [15:0] push_data,
  output logic        mem_write,
  output logic        mem_read,
  output logic        dec_sp,
  output logic        inc_sp,
  output logic        pc_restore,
  output logic [31:0] restored_pc,
  output logic        flags_restore,
  output logic [3:0]  restored_flags,
  output logic        in_isr
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] I_DRAIN = 4'd1;
  localparam logic [3:0] PUSH_HI = 4'd2;
  localparam logic [3:0] PUSH_LO = 4'd3;
  localparam logic [3:0] PUSH_FL = 4'd4;
  localparam logic [3:0] VECTOR  = 4'd5;
  localparam logic [3:0] R_DRAIN = 4'd6;
  localparam logic [3:0] POP_FL  = 4'd7;
  localparam logic [3:0] POP_LO  = 4'd8;
  localparam logic [3:0] POP_HI  = 4'd9;
  localparam logic [3:0] RESTORE = 4'd10;

  localparam int unsigned   CW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_CYCLES - 1);

  logic [3:0]    state;
  logic [3:0]    state_next;
  logic [CW-1:0] cnt;
  logic          int_req_q;
  logic          pending;
  logic          int_rise;
  logic          take_rti;
  logic          take_int;
  logic [31:0]   saved_pc;
  logic [3:0]    saved_flags;

  assign int_rise  = int_req & ~int_req_q;
  // RTI has priority; a request edge seen in the same IDLE cycle is acted on
  // immediately so the edge-detect cycle is also the decision cycle.
  assign take_rti  = (state == IDLE) & rti_req & in_isr;
  assign take_int  = (state == IDLE) & ~take_rti & ~in_isr & (pending | int_rise);
  assign vector_pc = VECTOR_ADDR;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take_rti)      state_next = R_DRAIN;
        else if (take_int) state_next = I_DRAIN;
      end
      I_DRAIN: if (cnt == CNT_LAST) state_next = PUSH_HI;
      PUSH_HI: state_next = PUSH_LO;
      PUSH_LO: state_next = PUSH_FL;
      PUSH_FL: state_next = VECTOR;
      VECTOR:  state_next = IDLE;
      R_DRAIN: if (cnt == CNT_LAST) state_next = POP_FL;
      POP_FL:  state_next = POP_LO;
      POP_LO:  state_next = POP_HI;
      POP_HI:  state_next = RESTORE;
      RESTORE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      int_req_q      <= 1'b0;
      pending        <= 1'b0;
      in_isr         <= 1'b0;
      saved_pc       <= '0;
      saved_flags    <= '0;
      restored_pc    <= '0;
      restored_flags <= '0;
    end else begin
      state     <= state_next;
      int_req_q <= int_req;

      // Clearing on entry wins over a simultaneous edge: that edge is the one
      // being serviced.
      if (take_int)      pending <= 1'b0;
      else if (int_rise) pending <= 1'b1;

      if (state != state_next)                        cnt <= '0;
      else if (state == I_DRAIN || state == R_DRAIN)  cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          if (take_int) begin
            saved_pc    <= resume_pc;
            saved_flags <= cur_flags;
          end
        end
        VECTOR:  in_isr <= 1'b1;
        POP_FL:  restored_flags <= mem_rdata[3:0];
        POP_LO:  restored_pc[15:0] <= mem_rdata;
        POP_HI:  restored_pc[31:16] <= mem_rdata;
        RESTORE: in_isr <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    stall         = 1'b0;
    flush         = 1'b0;
    interrupt     = 1'b0;
    int_mem_sel   = 2'b00;
    push_data     = '0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    dec_sp        = 1'b0;
    inc_sp        = 1'b0;
    pc_restore    = 1'b0;
    flags_restore = 1'b0;
    case (state)
      I_DRAIN, R_DRAIN: begin
        stall = 1'b1;
        flush = 1'b1;
      end
      PUSH_HI: begin
        stall       = 1'b1;
        mem_write   = 1'b1;
        dec_sp      = 1'b1;
        int_mem_sel = 2'b01;
        push_data   = saved_pc[31:16];
      end
      PUSH_LO: begin
        stall       = 1'b1;
        mem_write   = 1'b1;
        dec_sp      = 1'b1;
        int_mem_sel = 2'b10;
        push_data   = saved_pc[15:0];
      end
      PUSH_FL: begin
        stall       = 1'b1;
        mem_write   = 1'b1;
        dec_sp      = 1'b1;
        int_mem_sel = 2'b11;
        push_data   = {12'b0, saved_flags};
      end
      VECTOR: interrupt = 1'b1;
      POP_FL: begin
        stall       = 1'b1;
        mem_read    = 1'b1;
        inc_sp      = 1'b1;
        int_mem_sel = 2'b11;
      end
      POP_LO: begin
        stall       = 1'b1;
        mem_read    = 1'b1;
        inc_sp      = 1'b1;
        int_mem_sel = 2'b10;
      end
      POP_HI: begin
        stall       = 1'b1;
        mem_read    = 1'b1;
        inc_sp      = 1'b1;
        int_mem_sel = 2'b01;
      end
      RESTORE: begin
        pc_restore    = 1'b1;
        flags_restore = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller
//   Directed bench for interrupt_controller: reset mid-push, interrupt entry,
//   RTI return, ignored RTI, interrupt during ISR and RTI/interrupt priority.
//   Control outputs are packed into one word with hand-computed constants.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_req;
  logic        rti_req;
  logic [31:0] resume_pc;
  logic [3:0]  cur_flags;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        flush;
  logic        interrupt;
  logic [31:0] vector_pc;
  logic [1:0]  int_mem_sel;
  logic [15:0] push_data;
  logic        mem_write;
  logic        mem_read;
  logic        dec_sp;
  logic        inc_sp;
  logic        pc_restore;
  logic [31:0] restored_pc;
  logic        flags_restore;
  logic [3:0]  restored_flags;
  logic        in_isr;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] VEC = 32'h0000_0100;

  // {stall, flush, interrupt, mem_write, dec_sp, mem_read, inc_sp,
  //  pc_restore, flags_restore, int_mem_sel[1:0]}
  localparam logic [31:0] C_IDLE    = 32'h000;
  localparam logic [31:0] C_DRAIN   = 32'h600;
  localparam logic [31:0] C_PUSH_HI = 32'h4C1;
  localparam logic [31:0] C_PUSH_LO = 32'h4C2;
  localparam logic [31:0] C_PUSH_FL = 32'h4C3;
  localparam logic [31:0] C_VECTOR  = 32'h100;
  localparam logic [31:0] C_POP_FL  = 32'h433;
  localparam logic [31:0] C_POP_LO  = 32'h432;
  localparam logic [31:0] C_POP_HI  = 32'h431;
  localparam logic [31:0] C_RESTORE = 32'h00C;

  always #5 clk = ~clk;

  interrupt_controller #(
    .FLUSH_CYCLES(3),
    .VECTOR_ADDR (VEC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .int_req       (int_req),
    .rti_req       (rti_req),
    .resume_pc     (resume_pc),
    .cur_flags     (cur_flags),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .flush         (flush),
    .interrupt     (interrupt),
    .vector_pc     (vector_pc),
    .int_mem_sel   (int_mem_sel),
    .push_data     (push_data),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .dec_sp        (dec_sp),
    .inc_sp        (inc_sp),
    .pc_restore    (pc_restore),
    .restored_pc   (restored_pc),
    .flags_restore (flags_restore),
    .restored_flags(restored_flags),
    .in_isr        (in_isr)
  );

  function automatic logic [31:0] ctl();
    return {21'b0, stall, flush, interrupt, mem_write, dec_sp, mem_read, inc_sp,
            pc_restore, flags_restore, int_mem_sel};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Current cycle is the IDLE decision cycle (request edge or pending).
  task automatic expect_int_seq(input string tag, input logic [31:0] pc, input logic [3:0] fl);
    check({tag, "_c0"}, ctl(), C_IDLE);
    tick();
    resume_pc = ~pc;
    cur_flags = ~fl;
    check({tag, "_drain1"}, ctl(), C_DRAIN);
    tick();
    check({tag, "_drain2"}, ctl(), C_DRAIN);
    tick();
    check({tag, "_drain3"}, ctl(), C_DRAIN);
    tick();
    check({tag, "_push_hi"}, ctl(), C_PUSH_HI);
    check({tag, "_push_hi_d"}, {16'b0, push_data}, {16'b0, pc[31:16]});
    tick();
    check({tag, "_push_lo"}, ctl(), C_PUSH_LO);
    check({tag, "_push_lo_d"}, {16'b0, push_data}, {16'b0, pc[15:0]});
    tick();
    check({tag, "_push_fl"}, ctl(), C_PUSH_FL);
    check({tag, "_push_fl_d"}, {16'b0, push_data}, {28'b0, fl});
    tick();
    check({tag, "_vector"}, ctl(), C_VECTOR);
    check({tag, "_vector_pc"}, vector_pc, VEC);
    check({tag, "_isr_pre"}, {31'b0, in_isr}, 32'd0);
    tick();
    check({tag, "_after"}, ctl(), C_IDLE);
    check({tag, "_in_isr"}, {31'b0, in_isr}, 32'd1);
  endtask

  task automatic expect_rti_seq(input string tag, input logic [31:0] pc, input logic [3:0] fl);
    rti_req = 1'b1;
    check({tag, "_c0"}, ctl(), C_IDLE);
    tick();
    rti_req = 1'b0;
    check({tag, "_drain1"}, ctl(), C_DRAIN);
    tick();
    check({tag, "_drain2"}, ctl(), C_DRAIN);
    tick();
    check({tag, "_drain3"}, ctl(), C_DRAIN);
    tick();
    mem_rdata = {12'hFFF, fl};
    check({tag, "_pop_fl"}, ctl(), C_POP_FL);
    tick();
    mem_rdata = pc[15:0];
    check({tag, "_pop_lo"}, ctl(), C_POP_LO);
    check({tag, "_flags_early"}, {28'b0, restored_flags}, {28'b0, fl});
    tick();
    mem_rdata = pc[31:16];
    check({tag, "_pop_hi"}, ctl(), C_POP_HI);
    tick();
    mem_rdata = 16'h0000;
    check({tag, "_restore"}, ctl(), C_RESTORE);
    check({tag, "_rpc"}, restored_pc, pc);
    check({tag, "_rflags"}, {28'b0, restored_flags}, {28'b0, fl});
    check({tag, "_isr_pre"}, {31'b0, in_isr}, 32'd1);
    tick();
    check({tag, "_in_isr"}, {31'b0, in_isr}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    int_req   = 1'b0;
    rti_req   = 1'b0;
    resume_pc = '0;
    cur_flags = '0;
    mem_rdata = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_ctl", ctl(), C_IDLE);
    check("rst_isr", {31'b0, in_isr}, 32'd0);
    check("rst_vec", vector_pc, VEC);
    check("rst_rpc", restored_pc, 32'd0);

    // T1: reset asserted asynchronously in the middle of PUSH_LO
    resume_pc = 32'hAAAA_5555;
    cur_flags = 4'h6;
    int_req   = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t1_push_lo", ctl(), C_PUSH_LO);
    check("t1_push_lo_d", {16'b0, push_data}, 32'h0000_5555);
    #2 reset = 1'b1;
    #1;
    check("t1_async", ctl(), C_IDLE);
    int_req = 1'b0;
    tick();
    check("t1_held", ctl(), C_IDLE);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_no_pending", ctl(), C_IDLE);
    end
    check("t1_isr", {31'b0, in_isr}, 32'd0);

    // T2: interrupt entry
    resume_pc = 32'h0001_0024;
    cur_flags = 4'b1010;
    int_req   = 1'b1;
    expect_int_seq("t2", 32'h0001_0024, 4'b1010);
    int_req = 1'b0;
    tick();
    check("t2_idle", ctl(), C_IDLE);

    // T3: RTI restores what T2 pushed
    expect_rti_seq("t3", 32'h0001_0024, 4'b1010);

    // T4: RTI outside an ISR is ignored
    rti_req = 1'b1;
    tick();
    rti_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_ignored", ctl(), C_IDLE);
      tick();
    end

    // T5: interrupt during ISR waits for RESTORE
    resume_pc = 32'hDEAD_0010;
    cur_flags = 4'h5;
    int_req   = 1'b1;
    expect_int_seq("t5a", 32'hDEAD_0010, 4'h5);
    int_req = 1'b0;
    tick();
    int_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_held", ctl(), C_IDLE);
    end
    int_req   = 1'b0;
    resume_pc = 32'h0002_0040;
    cur_flags = 4'h3;
    expect_rti_seq("t5r", 32'hDEAD_0010, 4'h5);
    expect_int_seq("t5b", 32'h0002_0040, 4'h3);

    // T6: RTI and a new request edge in the same IDLE cycle
    tick();
    resume_pc = 32'h1234_5678;
    cur_flags = 4'hC;
    int_req   = 1'b1;
    expect_rti_seq("t6r", 32'h0002_0040, 4'h3);
    expect_int_seq("t6i", 32'h1234_5678, 4'hC);
    int_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
